ram_2k_32_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 2K x 32 program/data RAM (four byte-lane BRAMs) between the picorv32 native memory interface and a second master (boot loader / DMA fed from the port bus). Each requester uses a valid/ready handshake with byte write strobes. The arbiter sequences one RAM access at a time through a fixed four-state FSM and returns registered read data.

---
 rtl/ram_2k_32_arbiter.sv | 105 ++++++++++
 tb/tb_ram_2k_32_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram_2k_32_arbiter.sv
// ram_2k_32_arbiter: shares one 2K x 32 byte-lane RAM between two valid/ready requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module ram_2k_32_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [3:0]        m0_wstrb,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_wstrb,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACC, CAP, RESP} state_t;
  state_t state_q;
  logic gnt_q, gnt_d, wr_q;
  logic ram_en_q, m0_ready_q, m1_ready_q;
  logic [ADDR_W-1:0] ram_addr_q, addr_d;
  logic [3:0] ram_we_q, we_d;
  logic [31:0] ram_wdata_q, wdata_d, m0_rdata_q, m1_rdata_q;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0], m1_addr[31:ADDR_W+2], m1_addr[1:0]};
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign gnt_d = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
`else
  assign gnt_d = ~m0_valid;
`endif
  always_comb begin
    addr_d  = gnt_d ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
    we_d    = gnt_d ? m1_wstrb : m0_wstrb;
    wdata_d = gnt_d ? m1_wdata : m0_wdata;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      wr_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 4'h0;
      ram_wdata_q <= 32'h0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (m0_valid || m1_valid) begin
          gnt_q       <= gnt_d;
          wr_q        <= |we_d;
          ram_en_q    <= 1'b1;
          ram_addr_q  <= addr_d;
          ram_we_q    <= we_d;
          ram_wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_q <= gnt_d;
`endif
          state_q     <= ACC;
        end
        ACC: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 4'h0;
          state_q  <= CAP;
        end
        CAP: begin
          // RAM read data arrives one edge after the access, so capture it here
          if (!wr_q && !gnt_q) m0_rdata_q <= ram_rdata;
          if (!wr_q && gnt_q) m1_rdata_q <= ram_rdata;
          m0_ready_q <= ~gnt_q;
          m1_ready_q <= gnt_q;
          state_q    <= RESP;
        end
        default: begin
          m0_ready_q <= 1'b0;
          m1_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
endmodule

// File: tb/tb_ram_2k_32_arbiter.sv
// tb_ram_2k_32_arbiter: randomized bench for the RAM arbiter against a transaction-level memory model.
module tb_ram_2k_32_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic vld [2];
  logic [31:0] ra [2], wd [2];
  logic [3:0] st [2];
  logic m0_ready, m1_ready, ram_en;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [10:0] ram_addr;
  logic [3:0] ram_we;
  logic [31:0] bram [2048];
  logic [31:0] model_mem [2048];
  logic [31:0] exp_rd [2];
  int last_g = 1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ram_2k_32_arbiter #(.ADDR_W(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(vld[0]), .m0_addr(ra[0]), .m0_wstrb(st[0]), .m0_wdata(wd[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(vld[1]), .m1_addr(ra[1]), .m1_wstrb(st[1]), .m1_wdata(wd[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) if (ram_we[i]) bram[ram_addr][8*i+:8] <= ram_wdata[8*i+:8];
      ram_rdata <= bram[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return RR ? (last_g == 1 ? 0 : 1) : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic request(input int p, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    ra[p] = a; st[p] = s; wd[p] = d; vld[p] = 1'b1;
  endtask

  // Called at a falling edge with the arbiter idle (or about to arbitrate); port p must win.
  task automatic serve(input int p, input bit keep);
    int w;
    w = int'((ra[p] >> 2) % 2048);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("ram_en", ram_en, 1);
        check("ram_addr", ram_addr, w);
        check("ram_we", ram_we, st[p]);
        check("ram_wdata", ram_wdata, wd[p]);
      end
      if (c == 2) begin
        check("ram_en_pulse", ram_en, 0);
        check("ram_we_pulse", ram_we, 0);
      end
      if (c < 3) check(p ? "m1_early" : "m0_early", p ? m1_ready : m0_ready, 0);
    end
    check(p ? "m1_ready" : "m0_ready", p ? m1_ready : m0_ready, 1);
    check(p ? "m0_idle_rdy" : "m1_idle_rdy", p ? m0_ready : m1_ready, 0);
    if (st[p] == 4'h0) exp_rd[p] = model_mem[w];
    check(p ? "m1_rdata" : "m0_rdata", p ? m1_rdata : m0_rdata, exp_rd[p]);
    for (int i = 0; i < 4; i++) if (st[p][i]) model_mem[w][8*i+:8] = wd[p][8*i+:8];
    last_g = p;
    if (!keep) vld[p] = 1'b0;
    @(negedge clk);
    check(p ? "m1_pulse" : "m0_pulse", p ? m1_ready : m0_ready, 0);
  endtask

  initial begin
    bit v0, v1;
    int w;
    vld[0] = 0; vld[1] = 0;
    for (int p = 0; p < 2; p++) begin ra[p] = 0; st[p] = 0; wd[p] = 0; exp_rd[p] = 0; end
    repeat (3) @(negedge clk);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_rdata0", m0_rdata, 0);
    check("rst_rdata1", m1_rdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      request(1, i * 4, 4'hF, $urandom);
      serve(1, 0);
    end
    request(1, 32'h10, 4'hF, 32'hDEADBEEF);
    serve(1, 0);
    request(0, 32'h10, 4'h0, 32'h0);
    serve(0, 0);
    check("deadbeef", m0_rdata, 32'hDEADBEEF);
    request(1, 32'h14, 4'hF, 32'h11223344);
    serve(1, 0);
    request(0, 32'h14, 4'b0101, 32'hAABBCCDD);
    serve(0, 0);
    request(0, 32'h14, 4'h0, 32'h0);
    serve(0, 0);
    check("partial", m0_rdata, 32'h11BB33DD);
    request(1, 32'h2010, 4'h0, 32'h0);
    serve(1, 0);
    check("alias", m1_rdata, 32'hDEADBEEF);
    request(0, 32'h8, 4'h0, 32'h0);
    request(1, 32'hC, 4'h0, 32'h0);
    for (int t = 0; t < 4; t++) serve(pick(1, 1), 1);
    check("tie_last", last_g, RR ? 1 : 0);
    vld[0] = 0; vld[1] = 0;
    repeat (20) begin
      @(negedge clk);
      check("idle_en", ram_en, 0);
      check("idle_we", ram_we, 0);
      check("idle_rdy", {m0_ready, m1_ready}, 0);
    end
    request(0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    check("acc_en", ram_en, 1);
    reset_n = 1'b0;
    #1;
    check("arst_en", ram_en, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_we", ram_we, 0);
    check("arst_wdata", ram_wdata, 0);
    check("arst_rdy", {m0_ready, m1_ready}, 0);
    check("arst_rdata0", m0_rdata, 0);
    check("arst_rdata1", m1_rdata, 0);
    vld[0] = 0;
    exp_rd[0] = 0; exp_rd[1] = 0; last_g = 1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rdy", {m0_ready, m1_ready}, 0);
    end
    reset_n = 1'b1;
    request(0, 32'h10, 4'h0, 32'h0);
    serve(0, 0);
    check("post_rst", m0_rdata, 32'hDEADBEEF);
    for (int t = 0; t < 60; t++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      for (int p = 0; p < 2; p++) begin
        w = $urandom_range(0, 31);
        ra[p] = ($urandom & 32'hFFFF_E003) | (w << 2);
        st[p] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        wd[p] = $urandom;
      end
      vld[0] = v0; vld[1] = v1;
      w = pick(v0, v1);
      serve(w, 0);
      if (v0 && v1) serve(1 - w, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
